nrisc_wishbone_slave_ram: RTL and testbench



---
 rtl/nrisc_wishbone_slave_ram_if.sv | 31 +++
 rtl/nrisc_wishbone_slave_ram.sv | 82 ++++++++
 tb/tb_nrisc_wishbone_slave_ram.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nrisc_wishbone_slave_ram_if.sv
// Wishbone classic-cycle bus between an NRISC master and the slave RAM.
// Handshake: a request is CYC_IN & STRBIN; the slave answers with one ACK/ERR/RTY pulse gated by CYC_IN.
interface nrisc_wishbone_slave_ram_if #(
    parameter int TAM = 16
);
    logic             WSHSLV_CYC_IN;
    logic             WSHSLV_STRBIN;
    logic             WSHSLV_WREN;
    logic [TAM-1:0]   WSHSLV_ADDR_IN;
    logic [TAM/8-1:0] WSHSLV_SEL;
    logic [TAM-1:0]   WSHSLV_DATAIN;
    logic [7:0]       WSHSLV_TGDIN;
    logic             WSHSLV_HOLD;
    logic [TAM-1:0]   WSHSLV_DATAOUT;
    logic [7:0]       WSHSLV_TGDOUT;
    logic             WSHSLV_ACK;
    logic             WSHSLV_ERR;
    logic             WSHSLV_RTY;

    modport master (
        output WSHSLV_CYC_IN, WSHSLV_STRBIN, WSHSLV_WREN, WSHSLV_ADDR_IN,
               WSHSLV_SEL, WSHSLV_DATAIN, WSHSLV_TGDIN, WSHSLV_HOLD,
        input  WSHSLV_DATAOUT, WSHSLV_TGDOUT, WSHSLV_ACK, WSHSLV_ERR, WSHSLV_RTY
    );

    modport slave (
        input  WSHSLV_CYC_IN, WSHSLV_STRBIN, WSHSLV_WREN, WSHSLV_ADDR_IN,
               WSHSLV_SEL, WSHSLV_DATAIN, WSHSLV_TGDIN, WSHSLV_HOLD,
        output WSHSLV_DATAOUT, WSHSLV_TGDOUT, WSHSLV_ACK, WSHSLV_ERR, WSHSLV_RTY
    );
endinterface

// File: rtl/nrisc_wishbone_slave_ram.sv
// Wishbone classic slave fronting a byte-lane RAM with a per-word 8-bit tag.
// Every accepted cycle ends with one registered ACK, ERR or RTY one cycle later.
module nrisc_wishbone_slave_ram #(
    parameter int TAM     = 16,
    parameter int N_DData = 8
) (
    input  logic                           WSHSLV_CLKIN,
    input  logic                           WSHSLV_RSTIN,
    nrisc_wishbone_slave_ram_if.slave      bus,
    output logic                           dbg_state
);
    localparam int LANES = TAM / 8;
    localparam int DEPTH = 1 << N_DData;

    typedef enum logic { IDLE = 1'b0, RESP = 1'b1 } state_t;
    typedef enum logic [1:0] { RK_ACK = 2'd0, RK_ERR = 2'd1, RK_RTY = 2'd2 } rk_t;

    state_t           state;
    rk_t              rk;
    logic [TAM-1:0]   data_q;
    logic [7:0]       tag_q;

    logic [TAM-1:0]   ram [DEPTH];
    logic [7:0]       tag [DEPTH];

    logic [N_DData-1:0] idx;
    logic               req;
    logic               out_of_range;
    logic               wr_en;

    assign idx          = bus.WSHSLV_ADDR_IN[N_DData-1:0];
    assign req          = bus.WSHSLV_CYC_IN & bus.WSHSLV_STRBIN;
    assign out_of_range = |bus.WSHSLV_ADDR_IN[TAM-1:N_DData];
    assign wr_en        = ~WSHSLV_RSTIN & (state == IDLE) & req & ~out_of_range &
                          ~bus.WSHSLV_HOLD & ~bus.WSHSLV_WREN;

    always_ff @(posedge WSHSLV_CLKIN) begin
        if (WSHSLV_RSTIN) begin
            state  <= IDLE;
            rk     <= RK_ACK;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= RESP;
                        if (out_of_range) begin
                            rk <= RK_ERR;
                        end else if (bus.WSHSLV_HOLD) begin
                            rk <= RK_RTY;
                        end else begin
                            rk <= RK_ACK;
                            if (bus.WSHSLV_WREN) begin
                                data_q <= ram[idx];
                                tag_q  <= tag[idx];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive RSTIN.
    always_ff @(posedge WSHSLV_CLKIN) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.WSHSLV_SEL[i]) ram[idx][8*i +: 8] <= bus.WSHSLV_DATAIN[8*i +: 8];
            end
            if (|bus.WSHSLV_SEL) tag[idx] <= bus.WSHSLV_TGDIN;
        end
    end

    assign bus.WSHSLV_DATAOUT = data_q;
    assign bus.WSHSLV_TGDOUT  = tag_q;
    assign bus.WSHSLV_ACK     = (state == RESP) & (rk == RK_ACK) & bus.WSHSLV_CYC_IN;
    assign bus.WSHSLV_ERR     = (state == RESP) & (rk == RK_ERR) & bus.WSHSLV_CYC_IN;
    assign bus.WSHSLV_RTY     = (state == RESP) & (rk == RK_RTY) & bus.WSHSLV_CYC_IN;
    assign dbg_state          = state;
endmodule

// File: tb/tb_nrisc_wishbone_slave_ram.sv
// Bench for nrisc_wishbone_slave_ram: drives classic cycles, predicts each termination
// and the read data/tag with a RAM model, and compares them through a scoreboard queue.
module tb_nrisc_wishbone_slave_ram;
    localparam int TAM = 16;
    localparam int N_DData = 8;
    localparam int EW = 2 + 8 + TAM;  // {kind, tag, data}

    localparam logic [1:0] K_ACK = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;
    localparam logic [1:0] K_RTY = 2'd2;

    logic clk;
    logic rst;
    logic dbg_state;

    nrisc_wishbone_slave_ram_if #(.TAM(TAM)) bus();

    nrisc_wishbone_slave_ram #(.TAM(TAM), .N_DData(N_DData)) dut (
        .WSHSLV_CLKIN (clk),
        .WSHSLV_RSTIN (rst),
        .bus          (bus.slave),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [TAM-1:0] mem_m [1 << N_DData];
    logic [7:0]     tag_m [1 << N_DData];
    logic [TAM-1:0] last_d;
    logic [7:0]     last_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] terms();
        return {bus.WSHSLV_ACK, bus.WSHSLV_ERR, bus.WSHSLV_RTY};
    endfunction

    function automatic logic [1:0] obs_kind();
        if (bus.WSHSLV_ACK) return K_ACK;
        if (bus.WSHSLV_ERR) return K_ERR;
        if (bus.WSHSLV_RTY) return K_RTY;
        return 2'd3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Predict the outcome of one request and push it.
    task automatic predict(input logic rd, input logic [TAM-1:0] addr, input logic [TAM-1:0] wd,
                           input logic [TAM/8-1:0] sel, input logic [7:0] tg, input logic hold);
        logic [1:0] k;
        int a;
        a = int'(addr[N_DData-1:0]);
        if (addr[TAM-1:N_DData] != 0) k = K_ERR;
        else if (hold) k = K_RTY;
        else begin
            k = K_ACK;
            if (rd) begin
                last_d = mem_m[a];
                last_t = tag_m[a];
            end else begin
                for (int i = 0; i < TAM/8; i++)
                    if (sel[i]) mem_m[a][8*i +: 8] = wd[8*i +: 8];
                if (sel != 0) tag_m[a] = tg;
            end
        end
        exp_q.push_back({k, last_t, last_d});
    endtask

    task automatic check_resp(input string name);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_q_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_kind"}, 32'(obs_kind()), 32'(e[EW-1 -: 2]));
        check({name, "_data"}, 32'(bus.WSHSLV_DATAOUT), 32'(e[TAM-1:0]));
        check({name, "_tag"},  32'(bus.WSHSLV_TGDOUT), 32'(e[TAM +: 8]));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rd, input logic [TAM-1:0] addr, input logic [TAM-1:0] wd,
                         input logic [TAM/8-1:0] sel, input logic [7:0] tg, input logic hold);
        bus.WSHSLV_WREN    = rd;
        bus.WSHSLV_ADDR_IN = addr;
        bus.WSHSLV_DATAIN  = wd;
        bus.WSHSLV_SEL     = sel;
        bus.WSHSLV_TGDIN   = tg;
        bus.WSHSLV_HOLD    = hold;
    endtask

    // One single cycle; abort drops CYC right after the accept edge.
    task automatic xfer(input string name, input logic rd, input logic [TAM-1:0] addr,
                        input logic [TAM-1:0] wd, input logic [TAM/8-1:0] sel,
                        input logic [7:0] tg, input logic hold, input logic abort);
        logic [EW-1:0] dropped;
        predict(rd, addr, wd, sel, tg, hold);
        drive(rd, addr, wd, sel, tg, hold);
        bus.WSHSLV_CYC_IN = 1'b1;
        bus.WSHSLV_STRBIN = 1'b1;
        tick();
        bus.WSHSLV_STRBIN = 1'b0;
        bus.WSHSLV_HOLD   = ~hold;  // flipping HOLD in RESP must not matter
        if (abort) begin
            bus.WSHSLV_CYC_IN = 1'b0;
            #1;
            dropped = exp_q.pop_front();
            check({name, "_abort_term"}, 32'(terms()), 32'd0);
        end else begin
            check_resp(name);
        end
        tick();
        check({name, "_gap"}, 32'(terms()), 32'd0);
        bus.WSHSLV_CYC_IN = 1'b0;
        bus.WSHSLV_HOLD   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [TAM-1:0] rv;
        rst = 1'b1;
        bus.WSHSLV_CYC_IN = 1'b1;
        bus.WSHSLV_STRBIN = 1'b1;
        drive(1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0);
        last_d = '0;
        last_t = '0;

        // Reset with an active request on the bus.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_terms", 32'(terms()), 32'd0);
            check("rst_state", 32'(dbg_state), 32'd0);
        end
        check("rst_data", 32'(bus.WSHSLV_DATAOUT), 32'h0000);
        check("rst_tag",  32'(bus.WSHSLV_TGDOUT), 32'h00);
        rst = 1'b0;
        bus.WSHSLV_CYC_IN = 1'b0;
        bus.WSHSLV_STRBIN = 1'b0;
        tick();

        // Full write then read.
        xfer("wr_full", 1'b0, 16'h0005, 16'hBEEF, 2'b11, 8'hA5, 1'b0, 1'b0);
        xfer("rd_full", 1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);
        check("rd_full_lit", 32'(bus.WSHSLV_DATAOUT), 32'hBEEF);

        // Byte lane and empty-select writes.
        xfer("wr_lane0", 1'b0, 16'h0005, 16'h1234, 2'b01, 8'h3C, 1'b0, 1'b0);
        xfer("rd_lane0", 1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);
        check("rd_lane0_lit", 32'(bus.WSHSLV_DATAOUT), 32'hBE34);
        xfer("wr_sel0", 1'b0, 16'h0005, 16'hFFFF, 2'b00, 8'hFF, 1'b0, 1'b0);
        xfer("rd_sel0", 1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);
        check("rd_sel0_tag_lit", 32'(bus.WSHSLV_TGDOUT), 32'h3C);
        xfer("wr_lane1", 1'b0, 16'h0005, 16'h77AA, 2'b10, 8'h11, 1'b0, 1'b0);
        xfer("rd_lane1", 1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);

        // Error and retry, including priority of ERR over RTY.
        xfer("rd_oor",   1'b1, 16'h0100, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);
        xfer("wr_hold",  1'b0, 16'h0005, 16'hDEAD, 2'b11, 8'h99, 1'b1, 1'b0);
        xfer("rd_after_hold", 1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);
        xfer("oor_hold", 1'b0, 16'h8005, 16'hDEAD, 2'b11, 8'h99, 1'b1, 1'b0);
        xfer("rd_after_oor", 1'b1, 16'h0005, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);

        // Random fill of addresses 1..3.
        for (int a = 1; a <= 3; a++) begin
            rv = 16'($urandom_range(0, 16'hFFFF));
            xfer("wr_fill", 1'b0, 16'(a), rv, 2'b11, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end

        // Back-to-back reads with CYC/STRB held high.
        for (int a = 1; a <= 3; a++) predict(1'b1, 16'(a), 16'h0, 2'b11, 8'h0, 1'b0);
        drive(1'b1, 16'h0001, 16'h0000, 2'b11, 8'h00, 1'b0);
        bus.WSHSLV_CYC_IN = 1'b1;
        bus.WSHSLV_STRBIN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_resp("b2b");
            if (k < 2) bus.WSHSLV_ADDR_IN = 16'(k + 2);
            else bus.WSHSLV_STRBIN = 1'b0;
            tick();
            check("b2b_gap", 32'(terms()), 32'd0);
        end
        bus.WSHSLV_CYC_IN = 1'b0;

        // Aborted write still commits.
        xfer("wr_abort", 1'b0, 16'h0007, 16'hC0DE, 2'b11, 8'h5A, 1'b0, 1'b1);
        xfer("rd_abort", 1'b1, 16'h0007, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);
        check("rd_abort_lit", 32'(bus.WSHSLV_DATAOUT), 32'hC0DE);

        // Reset while in RESP.
        drive(1'b1, 16'h0001, 16'h0000, 2'b11, 8'h00, 1'b0);
        bus.WSHSLV_CYC_IN = 1'b1;
        bus.WSHSLV_STRBIN = 1'b1;
        tick();
        bus.WSHSLV_STRBIN = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_resp_terms", 32'(terms()), 32'd0);
        check("rst_resp_state", 32'(dbg_state), 32'd0);
        check("rst_resp_data",  32'(bus.WSHSLV_DATAOUT), 32'h0000);
        rst = 1'b0;
        bus.WSHSLV_CYC_IN = 1'b0;
        last_d = '0;
        last_t = '0;
        tick();
        xfer("rd_post_rst", 1'b1, 16'h0007, 16'h0000, 2'b11, 8'h00, 1'b0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
